vu_peak_decay: RTL and testbench

- Peak-hold and decay tracker for the VU meter bar.
- Consumes the instantaneous level, latches the maximum, and holds it for a programmable time.
- After the hold time it counts the held peak down one step per decay period until it reaches zero.
- Built around a loadable down-counter with terminal-count handling, the down-direction counterpart of the free-running up-counter used for timing elsewhere in the meter.

---
 rtl/vu_peak_decay.sv | 123 ++++++++++++
 tb/tb_vu_peak_decay.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vu_peak_decay.sv
// Peak-hold / decay tracker for the VU meter bar.
// Optional thermometer output peak_bar is enabled by defining VU_PEAK_BAR_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | peak is zero, waiting for a capture, timer parked at 0
// ST_HOLD  | peak frozen, timer counting down the hold interval
// ST_DECAY | peak drops one step each time the timer hits terminal count
module vu_peak_decay #(
    parameter int             w         = 4,
    parameter int             HOLD_CYC  = 16,
    parameter int             DECAY_CYC = 4,
    parameter logic [w-1:0]   initial_v = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              level_valid,
    input  logic [w-1:0]      level,
    output logic [w-1:0]      peak,
    output logic              holding,
`ifdef VU_PEAK_BAR_EN
    output logic              decaying,
    output logic [(2**w)-2:0] peak_bar
`else
    output logic              decaying
`endif
);

    localparam int TMR_MAX = (HOLD_CYC > DECAY_CYC) ? HOLD_CYC : DECAY_CYC;
    localparam int TW      = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);

    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] DECAY_LD = TW'(DECAY_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DECAY = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [w-1:0]  peak_nxt;
    logic          capture;
    logic          tmr_tc;

    assign capture = level_valid && (level != '0) && (level >= peak);
    assign tmr_tc  = (tmr == '0);

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        peak_nxt  = peak;
        if (capture) begin
            peak_nxt  = level;
            state_nxt = ST_HOLD;
            tmr_nxt   = HOLD_LD;
        end else begin
            case (state)
                ST_IDLE: tmr_nxt = '0;
                ST_HOLD: begin
                    if (tmr_tc) begin
                        state_nxt = ST_DECAY;
                        tmr_nxt   = DECAY_LD;
                    end else begin
                        tmr_nxt = tmr - TW'(1);
                    end
                end
                ST_DECAY: begin
                    if (tmr_tc) begin
                        tmr_nxt = DECAY_LD;
                        if (peak != '0) peak_nxt = peak - w'(1);
                        // Last step lands on zero: park in IDLE with the timer cleared.
                        if (peak <= w'(1)) begin
                            state_nxt = ST_IDLE;
                            tmr_nxt   = '0;
                        end
                    end else begin
                        tmr_nxt = tmr - TW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    tmr_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            peak <= initial_v;
            if (initial_v == '0) begin
                state <= ST_IDLE;
                tmr   <= '0;
            end else begin
                state <= ST_HOLD;
                tmr   <= HOLD_LD;
            end
        end else begin
            peak  <= peak_nxt;
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    assign holding  = (state == ST_HOLD);
    assign decaying = (state == ST_DECAY);

`ifdef VU_PEAK_BAR_EN
    function automatic logic [(2**w)-2:0] therm(input logic [w-1:0] v);
        logic [(2**w)-2:0] t;
        t = '0;
        for (int i = 0; i < (2**w) - 1; i++) t[i] = (int'(v) > i);
        return t;
    endfunction

    // Registered from the same next-peak value so it tracks peak with equal latency.
    always_ff @(posedge clk) begin
        if (!rst) peak_bar <= therm(initial_v);
        else      peak_bar <= therm(peak_nxt);
    end
`endif

endmodule

// File: tb/tb_vu_peak_decay.sv
// Bench for vu_peak_decay: default instance plus a HOLD_CYC=1/DECAY_CYC=1 instance,
// both compared every cycle against an age-based arithmetic model.
module tb_vu_peak_decay;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       level_valid = 1'b0;
    logic [3:0] level = '0;

    logic [3:0] peak_a, peak_b;
    logic       holding_a, holding_b, decaying_a, decaying_b;
`ifdef VU_PEAK_BAR_EN
    logic [14:0] bar_a, bar_b;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vu_peak_decay u_dut_a (
        .clk(clk), .rst(rst), .level_valid(level_valid), .level(level),
        .peak(peak_a), .holding(holding_a),
`ifdef VU_PEAK_BAR_EN
        .decaying(decaying_a), .peak_bar(bar_a)
`else
        .decaying(decaying_a)
`endif
    );

    vu_peak_decay #(.w(4), .HOLD_CYC(1), .DECAY_CYC(1)) u_dut_b (
        .clk(clk), .rst(rst), .level_valid(level_valid), .level(level),
        .peak(peak_b), .holding(holding_b),
`ifdef VU_PEAK_BAR_EN
        .decaying(decaying_b), .peak_bar(bar_b)
`else
        .decaying(decaying_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: peak is the captured value minus the decrements elapsed since capture.
    // Decrements fall at age H+D, H+2D, ... ; the meter holds for ages below H.
    int cap_a = 0, age_a = 0, cap_b = 0, age_b = 0;

    function automatic int m_peak(input int cap, input int age, input int h, input int d);
        int n;
        if (age < h + d) return cap;
        n = 1 + (age - h - d) / d;
        return (cap > n) ? cap - n : 0;
    endfunction

    function automatic logic [14:0] m_therm(input int pk);
        logic [14:0] t;
        for (int i = 0; i < 15; i++) t[i] = (pk > i);
        return t;
    endfunction

    task automatic model_edge(inout int cap, inout int age, input int h, input int d);
        int pk;
        pk = m_peak(cap, age, h, d);
        if (!rst) begin
            cap = 0; age = 0;
        end else if (level_valid && level != 0 && int'(level) >= pk) begin
            cap = int'(level); age = 0;
        end else if (pk > 0) begin
            age++;
        end
    endtask

    task automatic cyc(input logic r, input logic lv, input logic [3:0] lvl);
        int pa, pb;
        rst = r; level_valid = lv; level = lvl;
        @(posedge clk);
        model_edge(cap_a, age_a, 16, 4);
        model_edge(cap_b, age_b, 1, 1);
        @(negedge clk);
        pa = m_peak(cap_a, age_a, 16, 4);
        pb = m_peak(cap_b, age_b, 1, 1);
        chk("peak_a", 32'(peak_a), 32'(pa));
        chk("hold_a", 32'(holding_a), 32'(pa > 0 && age_a < 16));
        chk("decay_a", 32'(decaying_a), 32'(pa > 0 && age_a >= 16));
        chk("peak_b", 32'(peak_b), 32'(pb));
        chk("hold_b", 32'(holding_b), 32'(pb > 0 && age_b < 1));
        chk("decay_b", 32'(decaying_b), 32'(pb > 0 && age_b >= 1));
`ifdef VU_PEAK_BAR_EN
        chk("bar_a", 32'(bar_a), 32'(m_therm(pa)));
        chk("bar_b", 32'(bar_b), 32'(m_therm(pb)));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'd0);
    endtask

    initial begin
        // reset state
        cyc(1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 4'd7);
        chk("rst_peak", 32'(peak_a), 32'd0);
        chk("rst_hold", 32'(holding_a), 32'd0);

        // single pulse of 9 decays to zero after 52 edges
        cyc(1'b1, 1'b1, 4'd9);
        chk("cap9", 32'(peak_a), 32'd9);
        chk("cap9_hold", 32'(holding_a), 32'd1);
        idle(19);
        chk("pre_dec", 32'(peak_a), 32'd9);
        idle(1);
        chk("dec1", 32'(peak_a), 32'd8);
        idle(31);
        chk("last1", 32'(peak_a), 32'd1);
        chk("last1_decay", 32'(decaying_a), 32'd1);
        idle(1);
        chk("zero", 32'(peak_a), 32'd0);
        chk("zero_decay", 32'(decaying_a), 32'd0);

        // capture beats a due decrement
        cyc(1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b1, 4'd9);
        idle(19);
        chk("in_decay", 32'(decaying_a), 32'd1);
        cyc(1'b1, 1'b1, 4'd12);
        chk("cap12", 32'(peak_a), 32'd12);
        chk("cap12_hold", 32'(holding_a), 32'd1);
        idle(15);
        chk("rehold_end", 32'(holding_a), 32'd1);
        idle(1);
        chk("rehold_decay", 32'(decaying_a), 32'd1);

        // equal level re-arms hold, lower level ignored
        cyc(1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b1, 4'd9);
        idle(12);
        cyc(1'b1, 1'b1, 4'd9);
        cyc(1'b1, 1'b1, 4'd5);
        chk("low_ign", 32'(peak_a), 32'd9);
        idle(18);
        chk("rearm_pre", 32'(peak_a), 32'd9);
        idle(1);
        chk("rearm_dec", 32'(peak_a), 32'd8);

        // reset mid-decay at peak 5
        cyc(1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b1, 4'd9);
        idle(33);
        chk("pk5", 32'(peak_a), 32'd5);
        cyc(1'b0, 1'b0, 4'd0);
        chk("rst_mid_pk", 32'(peak_a), 32'd0);
        chk("rst_mid_dec", 32'(decaying_a), 32'd0);
        idle(2);
        chk("rst_mid_idle", 32'(peak_a), 32'd0);

        // fast instance: 3,3,2,1,0
        cyc(1'b1, 1'b1, 4'd3);
        chk("fast0", 32'(peak_b), 32'd3);
        idle(1);
        chk("fast1", 32'(peak_b), 32'd3);
        chk("fast1_dec", 32'(decaying_b), 32'd1);
        idle(1);
        chk("fast2", 32'(peak_b), 32'd2);
        idle(1);
        chk("fast3", 32'(peak_b), 32'd1);
        idle(1);
        chk("fast4", 32'(peak_b), 32'd0);
        chk("fast4_dec", 32'(decaying_b), 32'd0);

        // full scale
        cyc(1'b1, 1'b1, 4'd15);
        chk("full", 32'(peak_a), 32'd15);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
